// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a bank of NUM_REGS 32-bit word registers.
// Register 0 is a read-only ID. WAIT_CYCLES wait states precede pready.
// pslverr flags misaligned or out-of-range addresses.
// Optional macro APB_PSTRB_EN adds the pstrb port for byte-lane write strobes.
module apb_slave_regfile #(
    parameter int          ADDR_W      = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
`ifdef APB_PSTRB_EN
    input  logic [3:0]        pstrb,
`endif
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-3:0] REG_LIMIT = (ADDR_W-2)'(NUM_REGS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_err;
    logic              r_write;
    logic [31:0]       r_prdata;
    logic              r_pready;
    logic              r_pslverr;
    logic [31:0]       r_regs [NUM_REGS];

    logic [ADDR_W-3:0] w_idx_full;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic              w_latch;
    logic              w_enter_resp;
    logic              w_done;
    logic [IDX_W-1:0]  w_cur_idx;
    logic              w_cur_err;
    logic              w_cur_write;
    logic [31:0]       w_wmask;
    logic              w_commit;

    // Address decode of the current bus address (used only at the setup edge).
    always_comb begin
        w_idx_full = paddr[ADDR_W-1:2];
        w_idx      = w_idx_full[IDX_W-1:0];
        w_err      = (paddr[1:0] != 2'b00) || (w_idx_full >= REG_LIMIT);
    end

    // Byte-lane write mask: strobe-driven when enabled, otherwise full word.
`ifdef APB_PSTRB_EN
    always_comb begin
        w_wmask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
    end
`else
    always_comb begin
        w_wmask = '1;
    end
`endif

    // Next-state and control decode for the IDLE/WAIT/RESP handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_latch      = 1'b0;
        w_enter_resp = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (psel && !penable) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    // master abort: drop the transfer, nothing is committed
                    w_state_nxt = S_IDLE;
                end else if (penable) begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_done      = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the setup edge itself, so the
    // response must use the live decode instead of the not-yet-latched one.
    always_comb begin
        w_cur_idx   = w_latch ? w_idx  : r_idx;
        w_cur_err   = w_latch ? w_err  : r_err;
        w_cur_write = w_latch ? pwrite : r_write;
        w_commit    = w_done && r_write && !r_err && (r_idx != '0);
    end

    // State, wait counter and setup-phase latches.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_idx   <= w_idx;
                r_err   <= w_err;
                r_write <= pwrite;
            end
        end
    end

    // Registered response: pready/pslverr for one cycle, prdata only on reads.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else if (w_enter_resp) begin
            r_pready  <= 1'b1;
            r_pslverr <= w_cur_err;
            if (!w_cur_write) begin
                r_prdata <= w_cur_err          ? 32'd0    :
                            (w_cur_idx == '0)  ? ID_VALUE :
                                                 r_regs[w_cur_idx];
            end
        end else if (w_done) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end
    end

    // Register bank; writes land on the completing edge with pwdata sampled there.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[r_idx] <= (r_regs[r_idx] & ~w_wmask) | (pwdata & w_wmask);
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances with 0, 3 and 5 wait states
// driven as an APB master; a reference model predicts each response into a
// queue and every test pops and compares when pready is seen.
module tb_apb_slave_regfile;

    localparam int          NR = 8;
    localparam logic [31:0] ID = 32'hA0B0_0001;

    logic             pclk   = 1'b0;
    logic             preset = 1'b1;
    logic [2:0]       psel, penable, pwrite, pready, pslverr;
    logic [2:0][31:0] paddr, pwdata, prdata;
    logic [2:0][3:0]  pstrb;

    always #5 pclk = ~pclk;

    int cyc_cnt = 0;
    always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_regfile #(
            .ADDR_W(32), .NUM_REGS(NR),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 5)),
            .ID_VALUE(ID)
        ) u_dut (
            .pclk(pclk), .preset(preset),
            .psel(psel[g]), .penable(penable[g]), .pwrite(pwrite[g]),
            .paddr(paddr[g]), .pwdata(pwdata[g]),
`ifdef APB_PSTRB_EN
            .pstrb(pstrb[g]),
`endif
            .prdata(prdata[g]), .pready(pready[g]), .pslverr(pslverr[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        bit          rd;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
    } op_t;

    logic [31:0] mdl [3][NR];

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    // Reference model: compute the expected response, apply the write, queue it.
    task automatic predict(input int d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        exp_t        e;
        logic [29:0] idx;
        logic        err;
        int          i;
        idx    = addr[31:2];
        err    = (addr[1:0] != 2'b00) || (idx >= 30'(NR));
        i      = err ? 0 : int'(idx);
        e.cyc  = wc(d) + 1;
        e.err  = err;
        e.rd   = !wr;
        e.rdata = err ? 32'd0 : ((i == 0) ? ID : mdl[d][i]);
        if (wr && !err && i != 0) begin
`ifdef APB_PSTRB_EN
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][i][8*b +: 8] = wdata[8*b +: 8];
`else
            mdl[d][i] = wdata;
            if (strb == 4'hx) mdl[d][i] = 32'hx;
`endif
        end
        sb.push_back(e);
    endtask

    // One APB transfer on instance d; returns observed response, access-phase
    // length in cycles (-1 on timeout) and the cycle stamp of pready.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err,
                        output int cyc, output int at);
        @(negedge pclk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
        @(negedge pclk);
        penable[d] = 1'b1;
        cyc = 1;
        while (pready[d] !== 1'b1 && cyc < 40) begin
            @(negedge pclk);
            cyc++;
        end
        if (pready[d] !== 1'b1) cyc = -1;
        rd  = prdata[d];
        err = pslverr[d];
        at  = cyc_cnt;
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel = '0; penable = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({pready[d], pslverr[d], prdata[d]} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b err=%b rdata=%h want 0/0/0",
                         d, pready[d], pslverr[d], prdata[d]);
            end
        end
        preset = 1'b0;
    endtask

    task automatic test_wait0();
        op_t ops[2] = '{'{1'b1, 32'h04, 32'hDEADBEEF, 4'hF},
                        '{1'b0, 32'h04, 32'h0, 4'h0}};
        logic [31:0] rd; logic err; int cyc, at; exp_t e;
        foreach (ops[k]) begin
            predict(0, ops[k].wr, ops[k].a, ops[k].w, ops[k].s);
            xfer(0, ops[k].wr, ops[k].a, ops[k].w, ops[k].s, rd, err, cyc, at);
            e = sb.pop_front();
            n_tests++;
            if (cyc !== e.cyc) begin n_fail++;
                $display("FAIL wait0_latency op%0d: got %0d want %0d", k, cyc, e.cyc); end
            n_tests++;
            if (err !== e.err) begin n_fail++;
                $display("FAIL wait0_slverr op%0d: got %b want %b", k, err, e.err); end
            if (e.rd) begin
                n_tests++;
                if (rd !== e.rdata) begin n_fail++;
                    $display("FAIL wait0_rdata op%0d: got %h want %h", k, rd, e.rdata); end
            end
        end
        bus_idle();
    endtask

    task automatic test_wait3();
        op_t ops[4] = '{'{1'b0, 32'h00, 32'h0, 4'h0},
                        '{1'b1, 32'h00, 32'h12345678, 4'hF},
                        '{1'b0, 32'h00, 32'h0, 4'h0},
                        '{1'b0, 32'h03, 32'h0, 4'h0}};
        logic [31:0] rd; logic err; int cyc, at; exp_t e;
        foreach (ops[k]) begin
            predict(1, ops[k].wr, ops[k].a, ops[k].w, ops[k].s);
            xfer(1, ops[k].wr, ops[k].a, ops[k].w, ops[k].s, rd, err, cyc, at);
            e = sb.pop_front();
            n_tests++;
            if (cyc !== e.cyc) begin n_fail++;
                $display("FAIL wait3_latency op%0d: got %0d want %0d", k, cyc, e.cyc); end
            n_tests++;
            if (err !== e.err) begin n_fail++;
                $display("FAIL wait3_slverr op%0d: got %b want %b", k, err, e.err); end
            if (e.rd) begin
                n_tests++;
                if (rd !== e.rdata) begin n_fail++;
                    $display("FAIL wait3_rdata op%0d: got %h want %h", k, rd, e.rdata); end
            end
        end
        bus_idle();
    endtask

    task automatic test_errors();
        op_t ops[5] = '{'{1'b0, 32'h20, 32'h0, 4'h0},
                        '{1'b1, 32'h06, 32'h1, 4'hF},
                        '{1'b0, 32'h04, 32'h0, 4'h0},
                        '{1'b1, 32'h1C, 32'hCAFE0007, 4'hF},
                        '{1'b0, 32'h1C, 32'h0, 4'h0}};
        logic [31:0] rd; logic err; int cyc, at; exp_t e;
        foreach (ops[k]) begin
            predict(0, ops[k].wr, ops[k].a, ops[k].w, ops[k].s);
            xfer(0, ops[k].wr, ops[k].a, ops[k].w, ops[k].s, rd, err, cyc, at);
            e = sb.pop_front();
            n_tests++;
            if (err !== e.err) begin n_fail++;
                $display("FAIL err_slverr op%0d: got %b want %b", k, err, e.err); end
            if (e.rd) begin
                n_tests++;
                if (rd !== e.rdata) begin n_fail++;
                    $display("FAIL err_rdata op%0d: got %h want %h", k, rd, e.rdata); end
            end
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int cyc, at0, at1; exp_t e;
        predict(0, 1'b1, 32'h08, 32'h11, 4'hF);
        xfer(0, 1'b1, 32'h08, 32'h11, 4'hF, rd, err, cyc, at0);
        e = sb.pop_front();
        predict(0, 1'b0, 32'h08, 32'h0, 4'h0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc, at1);
        e = sb.pop_front();
        n_tests++;
        if (at1 - at0 !== 2) begin n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles want 2", at1 - at0); end
        n_tests++;
        if (rd !== e.rdata) begin n_fail++;
            $display("FAIL b2b_rdata: got %h want %h", rd, e.rdata); end
        bus_idle();
    endtask

`ifdef APB_PSTRB_EN
    task automatic test_pstrb();
        op_t ops[5] = '{'{1'b1, 32'h10, 32'hAABBCCDD, 4'b1111},
                        '{1'b1, 32'h10, 32'h11223344, 4'b0101},
                        '{1'b0, 32'h10, 32'h0, 4'b0000},
                        '{1'b1, 32'h10, 32'h99999999, 4'b0000},
                        '{1'b0, 32'h10, 32'h0, 4'b1010}};
        logic [31:0] rd; logic err; int cyc, at; exp_t e;
        foreach (ops[k]) begin
            predict(0, ops[k].wr, ops[k].a, ops[k].w, ops[k].s);
            xfer(0, ops[k].wr, ops[k].a, ops[k].w, ops[k].s, rd, err, cyc, at);
            e = sb.pop_front();
            n_tests++;
            if (err !== e.err) begin n_fail++;
                $display("FAIL pstrb_slverr op%0d: got %b want %b", k, err, e.err); end
            if (e.rd) begin
                n_tests++;
                if (rd !== e.rdata || rd !== 32'hAA22CC44) begin n_fail++;
                    $display("FAIL pstrb_rdata op%0d: got %h want %h", k, rd, 32'hAA22CC44); end
            end
        end
        bus_idle();
    endtask
`endif

    task automatic test_abort();
        logic [31:0] rd; logic err; int cyc, at; exp_t e;
        bit seen_rdy;
        @(negedge pclk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h0C; pwdata[2] = 32'hFF; pstrb[2] = 4'hF;
        @(negedge pclk);
        penable[2] = 1'b1;
        @(negedge pclk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        seen_rdy = 1'b0;
        repeat (10) begin
            @(negedge pclk);
            if (pready[2] !== 1'b0) seen_rdy = 1'b1;
        end
        n_tests++;
        if (seen_rdy) begin n_fail++;
            $display("FAIL abort_pready: got pready asserted want never"); end
        predict(2, 1'b0, 32'h0C, 32'h0, 4'h0);
        xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, rd, err, cyc, at);
        e = sb.pop_front();
        n_tests++;
        if (cyc !== e.cyc) begin n_fail++;
            $display("FAIL abort_read_latency: got %0d want %0d", cyc, e.cyc); end
        n_tests++;
        if (rd !== e.rdata) begin n_fail++;
            $display("FAIL abort_reg3: got %h want %h", rd, e.rdata); end
        bus_idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic err; int cyc, at; exp_t e;
        predict(2, 1'b1, 32'h04, 32'h55, 4'hF);
        xfer(2, 1'b1, 32'h04, 32'h55, 4'hF, rd, err, cyc, at);
        e = sb.pop_front();
        predict(2, 1'b0, 32'h00, 32'h0, 4'h0);
        xfer(2, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, cyc, at);
        e = sb.pop_front();
        n_tests++;
        if (rd !== e.rdata) begin n_fail++;
            $display("FAIL rst_pre_id: got %h want %h", rd, e.rdata); end
        // start a write and reset while it sits in wait states
        @(negedge pclk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h08; pwdata[2] = 32'h77; pstrb[2] = 4'hF;
        @(negedge pclk);
        penable[2] = 1'b1;
        @(negedge pclk);
        #2 preset = 1'b1;
        #1;
        n_tests++;
        if ({pready[2], pslverr[2], prdata[2]} !== 34'd0) begin n_fail++;
            $display("FAIL rst_async_dut2: got rdy=%b err=%b rdata=%h want 0/0/0",
                     pready[2], pslverr[2], prdata[2]); end
        n_tests++;
        if (prdata[0] !== 32'd0) begin n_fail++;
            $display("FAIL rst_async_dut0_rdata: got %h want 0", prdata[0]); end
        @(negedge pclk);
        psel = '0; penable = '0;
        preset = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < NR; i++) mdl[d][i] = 32'd0;
        for (int d = 0; d < 3; d += 2) begin
            for (int i = 1; i < NR; i++) begin
                predict(d, 1'b0, 32'(i * 4), 32'h0, 4'h0);
                xfer(d, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, cyc, at);
                e = sb.pop_front();
                n_tests++;
                if (rd !== e.rdata || cyc !== e.cyc) begin n_fail++;
                    $display("FAIL rst_clear dut%0d reg%0d: got %h (%0d cyc) want %h (%0d cyc)",
                             d, i, rd, cyc, e.rdata, e.cyc); end
            end
            bus_idle();
        end
    endtask

    initial begin
        psel = '0; penable = '0; pwrite = '0;
        paddr = '0; pwdata = '0; pstrb = '0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < NR; i++) mdl[d][i] = 32'd0;
        test_reset();
        test_wait0();
        test_wait3();
        test_errors();
        test_back_to_back();
`ifdef APB_PSTRB_EN
        test_pstrb();
`endif
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
